// File: rtl/sc_fir_out_drain_if.sv
// rtl/sc_fir_out_drain_if.sv - packed-frame input and lane stream bundle for sc_fir_out_drain
interface sc_fir_out_drain_if #(
    parameter int N     = 12,
    parameter int LANES = 4
) ();
    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [(N+1)*LANES-1:0] in;
    logic                   in_done;
    logic [N+1:0]           out_data;
    logic [LIW-1:0]         out_lane;
    logic                   out_last;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overflow;
    logic [15:0]            frame_cnt;
    logic                   busy;

    // master: the drain itself; slave: filter bank plus downstream consumer
    modport master (
        input  in, in_done, out_ready,
        output out_data, out_lane, out_last, out_valid, overflow, frame_cnt, busy
    );

    modport slave (
        output in, in_done, out_ready,
        input  out_data, out_lane, out_last, out_valid, overflow, frame_cnt, busy
    );
endinterface

// File: rtl/sc_fir_out_drain.sv
// rtl/sc_fir_out_drain.sv - frame FIFO and lane serializer for the SC FIR bank output
module sc_fir_out_drain #(
    parameter int N       = 12,
    parameter int LANES   = 4,
    parameter int DEPTH   = 2,
    parameter int BIPOLAR = 1
) (
    input  logic                clock,
    input  logic                reset,
    sc_fir_out_drain_if.master  bus
);
    localparam int LW  = N + 1;
    localparam int FW  = LW * LANES;
    localparam int DW  = N + 2;
    localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = PW + 1;

    localparam logic [LW-1:0]  FULL_SCALE = LW'(1) << N;
    localparam logic [DW-1:0]  OFFSET     = DW'(1) << N;
    localparam logic [LIW-1:0] LAST_LANE  = LIW'(LANES - 1);
    localparam logic [CW-1:0]  FIFO_FULL  = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [FW-1:0]   mem_q [DEPTH];
    logic [FW-1:0]   mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [LIW-1:0]  idx_q, idx_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     frame_cnt_q, frame_cnt_d;

    logic            xfer, pop, push, full;
    logic [FW-1:0]   head_next;
    logic [LW-1:0]   lane_next;

    function automatic logic [DW-1:0] convert(input logic [LW-1:0] v);
        logic [LW-1:0] c;
        c = (v > FULL_SCALE) ? FULL_SCALE : v;
        if (BIPOLAR != 0) begin
            convert = {c, 1'b0} - OFFSET;
        end else begin
            convert = {1'b0, v};
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;

        xfer = (state_q == SEND) && bus.out_ready;
        pop  = xfer && out_last_q;
        full = (count_q == FIFO_FULL);
        // a pop of the last lane frees the slot the incoming frame needs
        push = bus.in_done && (!full || pop);

        if (push) begin
            mem_d[wr_ptr_q] = bus.in;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (bus.in_done && full && !pop) begin
            overflow_d = 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);

        if (xfer) begin
            idx_d = out_last_q ? '0 : idx_q + LIW'(1);
        end

        // outputs are registered, so look ahead at the head as it will be after this edge
        head_next = (push && (count_q - CW'(pop)) == '0) ? bus.in : mem_q[rd_ptr_d];
        lane_next = head_next[int'(idx_d) * LW +: LW];

        if (count_d != '0) begin
            state_d     = SEND;
            out_valid_d = 1'b1;
            out_last_d  = (idx_d == LAST_LANE);
            out_data_d  = convert(lane_next);
        end else begin
            state_d = IDLE;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_lane  = idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.overflow  = overflow_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.busy      = (count_q != '0) || out_valid_q;
endmodule

// File: tb/tb_sc_fir_out_drain.sv
// tb/tb_sc_fir_out_drain.sv - directed bench for sc_fir_out_drain, bipolar and unipolar builds
module tb_sc_fir_out_drain;
    logic        clock = 1'b0;
    logic        rst_r = 1'b1;
    logic        done_r = 1'b0;
    logic        rdy_r = 1'b0;
    logic [51:0] in_r = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sc_fir_out_drain_if #(.N(12), .LANES(4)) bus_b ();
    sc_fir_out_drain_if #(.N(12), .LANES(4)) bus_u ();

    assign bus_b.in        = in_r;
    assign bus_b.in_done   = done_r;
    assign bus_b.out_ready = rdy_r;
    assign bus_u.in        = in_r;
    assign bus_u.in_done   = done_r;
    assign bus_u.out_ready = rdy_r;

    sc_fir_out_drain #(.N(12), .LANES(4), .DEPTH(2), .BIPOLAR(1)) dut_b (
        .clock (clock),
        .reset (rst_r),
        .bus   (bus_b)
    );

    sc_fir_out_drain #(.N(12), .LANES(4), .DEPTH(2), .BIPOLAR(0)) dut_u (
        .clock (clock),
        .reset (rst_r),
        .bus   (bus_u)
    );

    typedef struct {
        logic        rst;
        logic        done;
        logic        rdy;
        logic [51:0] frame;
        logic        v;
        logic [13:0] d;
        logic [13:0] ud;
        logic [1:0]  ln;
        logic        lst;
        logic        ovf;
        logic [15:0] fc;
        logic        bsy;
    } vec_t;

    vec_t tbl [19];

    function automatic logic [51:0] pack(input int l0, input int l1, input int l2, input int l3);
        logic [12:0] a, b, c, d;
        a = 13'(l0); b = 13'(l1); c = 13'(l2); d = 13'(l3);
        return {d, c, b, a};
    endfunction

    function automatic logic [13:0] bip(input int x);
        int c;
        c = (x > 4096) ? 4096 : x;
        return 14'(2 * c - 4096);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rst_r = 1'b1; done_r = 1'b0; rdy_r = 1'b0;
        step();
        rst_r = 1'b0;
    endtask

    logic [51:0] f1, f3, fa, fb, fc;
    int          exp_lanes [12];
    int          n, gaps;

    initial begin
        f1 = pack(0, 2048, 4096, 4095);
        f3 = pack(8191, 1, 4097, 2049);
        fa = pack(100, 200, 300, 400);
        fb = pack(1000, 1100, 1200, 1300);
        fc = pack(7, 8, 9, 10);

        tbl[0]  = '{1, 0, 1, '0, 0, 14'h0000, 14'h0000, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 1, f1, 1, 14'h3000, 14'h0000, 0, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 1, '0, 1, 14'h0000, 14'h0800, 1, 0, 0, 0, 1};
        tbl[3]  = '{0, 0, 1, '0, 1, 14'h1000, 14'h1000, 2, 0, 0, 0, 1};
        tbl[4]  = '{0, 0, 1, '0, 1, 14'h0FFE, 14'h0FFF, 3, 1, 0, 0, 1};
        tbl[5]  = '{0, 0, 1, '0, 0, 14'h0000, 14'h0000, 0, 0, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, f1, 1, 14'h3000, 14'h0000, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 0, 1, '0, 1, 14'h0000, 14'h0800, 1, 0, 0, 1, 1};
        tbl[8]  = '{0, 0, 0, '0, 1, 14'h0000, 14'h0800, 1, 0, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, '0, 1, 14'h0000, 14'h0800, 1, 0, 0, 1, 1};
        tbl[10] = '{0, 0, 0, '0, 1, 14'h0000, 14'h0800, 1, 0, 0, 1, 1};
        tbl[11] = '{0, 0, 1, '0, 1, 14'h1000, 14'h1000, 2, 0, 0, 1, 1};
        tbl[12] = '{0, 0, 1, '0, 1, 14'h0FFE, 14'h0FFF, 3, 1, 0, 1, 1};
        tbl[13] = '{0, 0, 1, '0, 0, 14'h0000, 14'h0000, 0, 0, 0, 2, 0};
        tbl[14] = '{0, 1, 1, f3, 1, 14'h1000, 14'h1FFF, 0, 0, 0, 2, 1};
        tbl[15] = '{0, 0, 1, '0, 1, 14'h3002, 14'h0001, 1, 0, 0, 2, 1};
        tbl[16] = '{0, 0, 1, '0, 1, 14'h1000, 14'h1001, 2, 0, 0, 2, 1};
        tbl[17] = '{0, 0, 1, '0, 1, 14'h0002, 14'h0801, 3, 1, 0, 2, 1};
        tbl[18] = '{0, 0, 1, '0, 0, 14'h0000, 14'h0000, 0, 0, 0, 3, 0};

        @(negedge clock);
        for (int i = 0; i < 19; i++) begin
            rst_r = tbl[i].rst; done_r = tbl[i].done; rdy_r = tbl[i].rdy; in_r = tbl[i].frame;
            step();
            chk($sformatf("row%0d valid", i), 32'(bus_b.out_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d uvalid", i), 32'(bus_u.out_valid), 32'(tbl[i].v));
            chk($sformatf("row%0d overflow", i), 32'(bus_b.overflow), 32'(tbl[i].ovf));
            chk($sformatf("row%0d frame_cnt", i), 32'(bus_b.frame_cnt), 32'(tbl[i].fc));
            chk($sformatf("row%0d busy", i), 32'(bus_b.busy), 32'(tbl[i].bsy));
            if (tbl[i].v) begin
                chk($sformatf("row%0d data", i), 32'(bus_b.out_data), 32'(tbl[i].d));
                chk($sformatf("row%0d udata", i), 32'(bus_u.out_data), 32'(tbl[i].ud));
                chk($sformatf("row%0d lane", i), 32'(bus_b.out_lane), 32'(tbl[i].ln));
                chk($sformatf("row%0d last", i), 32'(bus_b.out_last), 32'(tbl[i].lst));
            end
        end

        // overflow: three frames into a two-deep FIFO with the stream stalled
        do_reset();
        done_r = 1'b1; in_r = fa; step();
        in_r = fb; step();
        in_r = fc; step();
        done_r = 1'b0;
        chk("ovf set", 32'(bus_b.overflow), 32'd1);
        chk("ovf head lane", 32'(bus_b.out_lane), 32'd0);
        chk("ovf head data", 32'(bus_b.out_data), 32'(bip(100)));
        exp_lanes = '{100, 200, 300, 400, 1000, 1100, 1200, 1300, 0, 0, 0, 0};
        rdy_r = 1'b1;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus_b.out_valid) begin
                if (n < 8) begin
                    chk($sformatf("ovf xfer%0d data", n), 32'(bus_b.out_data), 32'(bip(exp_lanes[n])));
                    chk($sformatf("ovf xfer%0d lane", n), 32'(bus_b.out_lane), 32'(n % 4));
                end
                n++;
            end
            step();
        end
        chk("ovf transfers", 32'(n), 32'd8);
        chk("ovf frame_cnt", 32'(bus_b.frame_cnt), 32'd2);
        chk("ovf sticky", 32'(bus_b.overflow), 32'd1);
        chk("ovf busy", 32'(bus_b.busy), 32'd0);

        // full FIFO with in_done on the accepted last lane of the head
        do_reset();
        done_r = 1'b1; in_r = fa; step();
        in_r = fb; step();
        done_r = 1'b0;
        exp_lanes = '{100, 200, 300, 400, 1000, 1100, 1200, 1300, 7, 8, 9, 10};
        rdy_r = 1'b1;
        n = 0; gaps = 0;
        for (int c = 0; c < 40; c++) begin
            done_r = 1'b0;
            if (bus_b.out_valid) begin
                if (n < 12) begin
                    chk($sformatf("sim xfer%0d data", n), 32'(bus_b.out_data), 32'(bip(exp_lanes[n])));
                    chk($sformatf("sim xfer%0d last", n), 32'(bus_b.out_last), 32'((n % 4) == 3));
                end
                n++;
                if (bus_b.out_last && n == 4) begin
                    done_r = 1'b1; in_r = fc;
                end
            end else if (n > 0 && n < 12) begin
                gaps++;
            end
            step();
        end
        done_r = 1'b0;
        chk("sim transfers", 32'(n), 32'd12);
        chk("sim gaps", 32'(gaps), 32'd0);
        chk("sim overflow", 32'(bus_b.overflow), 32'd0);
        chk("sim frame_cnt", 32'(bus_b.frame_cnt), 32'd3);

        // reset mid-frame with two frames queued; coincident in_done is ignored
        do_reset();
        done_r = 1'b1; in_r = fa; step();
        in_r = fb; step();
        done_r = 1'b0; rdy_r = 1'b1;
        step(); step();
        chk("rst pre lane", 32'(bus_b.out_lane), 32'd2);
        rst_r = 1'b1; done_r = 1'b1; in_r = fc;
        step();
        rst_r = 1'b0; done_r = 1'b0;
        chk("rst valid", 32'(bus_b.out_valid), 32'd0);
        chk("rst busy", 32'(bus_b.busy), 32'd0);
        chk("rst frame_cnt", 32'(bus_b.frame_cnt), 32'd0);
        step();
        chk("rst ignored done", 32'(bus_b.busy), 32'd0);
        done_r = 1'b1; in_r = fc; step();
        done_r = 1'b0;
        chk("rst new valid", 32'(bus_b.out_valid), 32'd1);
        chk("rst new lane0", 32'(bus_b.out_lane), 32'd0);
        chk("rst new data0", 32'(bus_b.out_data), 32'(bip(7)));
        step();
        chk("rst new lane1", 32'(bus_b.out_lane), 32'd1);
        chk("rst new data1", 32'(bus_b.out_data), 32'(bip(8)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
